// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_mem_pkg
// Purpose : Shared types and constants for the byte-lane data-memory
//           responder: byte type, lanes per word and responder FSM states.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    typedef logic [7:0] byte_t;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/mips_byte_ram.sv
`default_nettype none
// ============================================================================
// Module  : mips_byte_ram
// Purpose : MEM_BYTES x 8 byte storage with a 4-lane big-endian port.
//           Lane k addresses (addr + k) mod MEM_BYTES, so accesses wrap at
//           the top of memory. Read is combinational; write is on clk when
//           we is high. The storage has no reset.
// Ports   : clk   - clock, rising edge
//           we    - write all 4 lanes at this edge
//           addr  - base byte address of lane 0 (already reduced mod size)
//           wdata - write lanes, lane 0 is the most significant byte
//           rdata - read lanes at addr, addr+1, addr+2, addr+3
// Revision: 1.0 - initial release
// ============================================================================
module mips_byte_ram
    import mips_mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [$clog2(MEM_BYTES)-1:0]        addr,
    input  byte_t [0:WORD_BYTES-1]              wdata,
    output byte_t [0:WORD_BYTES-1]              rdata
);

    localparam int c_addr_w = $clog2(MEM_BYTES);

    byte_t               r_mem       [0:MEM_BYTES-1];
    logic [c_addr_w-1:0] w_lane_addr [0:WORD_BYTES-1];

    // Each lane's address is truncated to c_addr_w bits, giving the
    // per-lane wrap without any alignment restriction.
    generate
        for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
            assign w_lane_addr[k] = addr + c_addr_w'(k);
            assign rdata[k]       = r_mem[w_lane_addr[k]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                r_mem[w_lane_addr[k]] <= wdata[k];
            end
        end
    end

endmodule : mips_byte_ram
`default_nettype wire

// File: rtl/mips_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mips_data_mem_responder
// Purpose : Memory-side responder for the core's byte-lane data interface.
//           One request at a time with valid/ready handshake; the access
//           happens LATENCY edges after the accept edge and is followed by
//           a one-cycle resp_valid strobe. Reads and writes both return the
//           pre-write contents of the 4 lanes.
// Option  : MEM_MISALIGN_ERR_EN - adds resp_err; accesses with addr[1:0]!=0
//           do not write, return zero lanes and flag resp_err.
// Ports   : clk, rst (async, active-high), halted (blocks new accepts)
//           req_valid/req_ready/req_we/req_addr/req_data_in - request
//           resp_valid/resp_data_out[/resp_err]             - response
// Revision: 1.0 - initial release
// ============================================================================
module mips_data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halted,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [31:0]            req_addr,
    input  byte_t [0:WORD_BYTES-1] req_data_in,
    output logic                   resp_valid,
    output byte_t [0:WORD_BYTES-1] resp_data_out
`ifdef MEM_MISALIGN_ERR_EN
    ,
    output logic                   resp_err
`endif
);

    localparam int                c_addr_w   = $clog2(MEM_BYTES);
    localparam int                c_cnt_w    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);

    mem_state_e             r_state;
    mem_state_e             w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_addr_w-1:0]    r_addr;
    logic                   r_we;
    byte_t [0:WORD_BYTES-1] r_wdata;
    byte_t [0:WORD_BYTES-1] w_rdata;
    logic                   w_accept;
    logic                   w_access;
    logic                   w_ram_we;
    logic                   w_unused;

    // Upper address bits are ignored by design.
    assign w_unused = ^req_addr[31:c_addr_w];

    assign req_ready = (r_state == IDLE) && !halted && !rst;
    assign w_accept  = req_valid && req_ready;
    // Access edge: last BUSY cycle, counter exhausted.
    assign w_access  = (r_state == BUSY) && (r_cnt == '0);

`ifdef MEM_MISALIGN_ERR_EN
    logic r_mis;
    assign w_ram_we = w_access && r_we && !r_mis;
`else
    assign w_ram_we = w_access && r_we;
`endif

    mips_byte_ram #(
        .MEM_BYTES (MEM_BYTES)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (r_addr),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = BUSY;
            BUSY:    if (r_cnt == '0) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------- request latch and response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            resp_valid    <= 1'b0;
            resp_data_out <= '0;
`ifdef MEM_MISALIGN_ERR_EN
            r_mis         <= 1'b0;
            resp_err      <= 1'b0;
`endif
        end else begin
            resp_valid <= w_access;
            if (w_accept) begin
                r_cnt   <= c_cnt_load;
                r_addr  <= req_addr[c_addr_w-1:0];
                r_we    <= req_we;
                r_wdata <= req_data_in;
`ifdef MEM_MISALIGN_ERR_EN
                r_mis   <= (req_addr[1:0] != 2'b00);
`endif
            end else if ((r_state == BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // Read data is captured from the combinational RAM port before
            // the same edge commits any write, so writes ack old contents.
            if (w_access) begin
`ifdef MEM_MISALIGN_ERR_EN
                resp_data_out <= r_mis ? '0 : w_rdata;
                resp_err      <= r_mis;
`else
                resp_data_out <= w_rdata;
`endif
            end
        end
    end

endmodule : mips_data_mem_responder
`default_nettype wire

// File: tb/tb_mips_data_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_mips_data_mem_responder
// Purpose : Directed self-checking bench for mips_data_mem_responder, one
//           instance at LATENCY=2 and one at LATENCY=1.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_data_mem_responder;
    import mips_mem_pkg::*;

    localparam int c_lat = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   halted;
    logic                   req_valid, req_ready, req_we;
    logic [31:0]            req_addr;
    byte_t [0:WORD_BYTES-1] req_data_in;
    logic                   resp_valid;
    byte_t [0:WORD_BYTES-1] resp_data_out;

    logic                   req_valid1, req_ready1, req_we1;
    logic [31:0]            req_addr1;
    byte_t [0:WORD_BYTES-1] req_data_in1;
    logic                   resp_valid1;
    byte_t [0:WORD_BYTES-1] resp_data_out1;
`ifdef MEM_MISALIGN_ERR_EN
    logic                   resp_err, resp_err1;
`endif

    mips_data_mem_responder #(.MEM_BYTES(1024), .LATENCY(c_lat)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .halted        (halted),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_data_in   (req_data_in),
        .resp_valid    (resp_valid),
        .resp_data_out (resp_data_out)
`ifdef MEM_MISALIGN_ERR_EN
        ,
        .resp_err      (resp_err)
`endif
    );

    mips_data_mem_responder #(.MEM_BYTES(1024), .LATENCY(1)) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .halted        (halted),
        .req_valid     (req_valid1),
        .req_ready     (req_ready1),
        .req_we        (req_we1),
        .req_addr      (req_addr1),
        .req_data_in   (req_data_in1),
        .resp_valid    (resp_valid1),
        .resp_data_out (resp_data_out1)
`ifdef MEM_MISALIGN_ERR_EN
        ,
        .resp_err      (resp_err1)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access on the LATENCY=2 instance, checking the handshake
    // timing on the way. Returns the response lanes.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] d, output logic [31:0] q);
        int n;
        req_we = we; req_addr = addr; req_data_in = d; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        chk($sformatf("%s ready_before", tag), {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk($sformatf("%s ready_busy", tag), {31'd0, req_ready}, 32'd0);
        n = 0;
        while (!resp_valid && n < 20) begin step(); n++; end
        chk($sformatf("%s latency", tag), n, c_lat);
        q = resp_data_out;
`ifdef MEM_MISALIGN_ERR_EN
        last_err = resp_err;
`else
        last_err = 1'b0;
`endif
        chk($sformatf("%s ready_resp", tag), {31'd0, req_ready}, 32'd0);
        step();
        chk($sformatf("%s resp_drop", tag), {31'd0, resp_valid}, 32'd0);
        chk($sformatf("%s ready_after", tag), {31'd0, req_ready}, 32'd1);
    endtask

    // Access on the LATENCY=1 instance: response must follow one edge later.
    task automatic access1(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] d, output logic [31:0] q);
        req_we1 = we; req_addr1 = addr; req_data_in1 = d; req_valid1 = 1'b1;
        chk($sformatf("%s ready1", tag), {31'd0, req_ready1}, 32'd1);
        step();
        req_valid1 = 1'b0;
        chk($sformatf("%s resp1_E0", tag), {31'd0, resp_valid1}, 32'd0);
        step();
        chk($sformatf("%s resp1_E1", tag), {31'd0, resp_valid1}, 32'd1);
        q = resp_data_out1;
        step();
        chk($sformatf("%s resp1_drop", tag), {31'd0, resp_valid1}, 32'd0);
        chk($sformatf("%s ready1_after", tag), {31'd0, req_ready1}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] q;
        int acc_cnt, acc_idx0, acc_idx1, resp_cnt, b2b;
        logic prev_rv;
        int seen;

        rst = 1'b1; halted = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data_in = '0;
        req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_data_in1 = '0;
        step(); step();

        // Reset state
        chk("rst ready", {31'd0, req_ready}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_data", resp_data_out, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst ready", {31'd0, req_ready}, 32'd1);
        step();

        // 1. Write then read back
        access("t1 wr", 1'b1, 32'h10, 32'h11223344, q);
        access("t1 rd", 1'b0, 32'h10, 32'h0, q);
        chk("t1 rd data", q, 32'h11223344);

        // 2. Wrap at top of memory, upper address bits ignored
        access("t2 wr", 1'b1, 32'h3FE, 32'hAABBCCDD, q);
        access("t2 rd", 1'b0, 32'hFFFFFBFE, 32'h0, q);
        chk("t2 rd data", q, 32'hAABBCCDD);
        access("t2 rd0", 1'b0, 32'h0, 32'h0, q);
        chk("t2 wrap lanes", {16'd0, q[31:16]}, 32'h0000CCDD);

        // 3. Write ack returns old contents
        access("t3 init", 1'b1, 32'h20, 32'h01020304, q);
        access("t3 wr", 1'b1, 32'h20, 32'hA1A2A3A4, q);
        chk("t3 ack old", q, 32'h01020304);
        access("t3 rd", 1'b0, 32'h20, 32'h0, q);
        chk("t3 rd new", q, 32'hA1A2A3A4);

        // 4. req_valid held high over two reads
        access("t4 init", 1'b1, 32'h30, 32'h55667788, q);
        req_we = 1'b0; req_addr = 32'h30; req_valid = 1'b1;
        acc_cnt = 0; acc_idx0 = -1; acc_idx1 = -1; resp_cnt = 0; b2b = 0; prev_rv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) begin
                resp_cnt++;
                if (prev_rv) b2b++;
            end
            prev_rv = resp_valid;
            if (req_valid && req_ready) begin
                if (acc_cnt == 0) acc_idx0 = i; else acc_idx1 = i;
                acc_cnt++;
            end
            step();
        end
        req_valid = 1'b0;
        chk("t4 accepts", acc_cnt, 2);
        chk("t4 accept gap", acc_idx1 - acc_idx0, 4);
        chk("t4 resp count", resp_cnt, 2);
        chk("t4 back2back", b2b, 0);
        chk("t4 data", resp_data_out, 32'h55667788);
        step();

        // 5a. Reset in the cycle after accepting a write drops it
        access("t5 init", 1'b1, 32'h40, 32'h5A5B5C5D, q);
        req_we = 1'b1; req_addr = 32'h40; req_data_in = 32'hDEADBEEF; req_valid = 1'b1;
        chk("t5 ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5 rst ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("t5 idle after rst", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (resp_valid) seen++;
        end
        chk("t5 no resp", seen, 0);
        access("t5 rd", 1'b0, 32'h40, 32'h0, q);
        chk("t5 old data", q, 32'h5A5B5C5D);

        // 5b. halted blocks new requests
        halted = 1'b1;
        req_we = 1'b1; req_addr = 32'h40; req_data_in = 32'h12345678; req_valid = 1'b1;
        #1;
        chk("t5 halted ready", {31'd0, req_ready}, 32'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (resp_valid || req_ready) seen++;
        end
        chk("t5 halted idle", seen, 0);
        req_valid = 1'b0; halted = 1'b0;
        step();
        access("t5 rd2", 1'b0, 32'h40, 32'h0, q);
        chk("t5 halted no write", q, 32'h5A5B5C5D);

        // 6a. LATENCY=1 instance
        access1("t6 wr", 1'b1, 32'h8, 32'hCAFEF00D, q);
        access1("t6 rd", 1'b0, 32'h8, 32'h0, q);
        chk("t6 rd data", q, 32'hCAFEF00D);

        // 6b. Misaligned write to 0x11 (0x10..0x13 hold 11 22 33 44)
        access("t6 mis wr", 1'b1, 32'h11, 32'hE1E2E3E4, q);
`ifdef MEM_MISALIGN_ERR_EN
        chk("t6 mis err", {31'd0, last_err}, 32'd1);
        chk("t6 mis lanes", q, 32'h0);
        access("t6 mis rd", 1'b0, 32'h10, 32'h0, q);
        chk("t6 mem unchanged", q, 32'h11223344);
        chk("t6 aligned err", {31'd0, last_err}, 32'd0);
`else
        chk("t6 mis ack old", q, 32'h22334400 | {24'd0, q[7:0]});
        access("t6 mis rd", 1'b0, 32'h11, 32'h0, q);
        chk("t6 mis rd data", q, 32'hE1E2E3E4);
        access("t6 rd10", 1'b0, 32'h10, 32'h0, q);
        chk("t6 lane0 kept", q, 32'h11E1E2E3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mips_data_mem_responder
`default_nettype wire
